// File: rtl/cla_pipelined_addsub.sv
// Pipelined carry-lookahead add/sub: WIDTH bits split into STAGES segments of 4-bit P/G groups.
// Latency STAGES cycles, one operation per cycle at full throughput.
// Backpressure: a single global stall; all stages hold while out_valid && !out_ready, in_ready follows it.
module cla_pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage pipeline state. Operand registers are kept at full width so that
  // every stage indexes the same bit positions; bits that are already consumed
  // (and the whole final-stage copy) are never read and fall away in synthesis.
  logic                         advance;
  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0]            cry_q, cry_d;
  logic [STAGES-1:0][WIDTH-1:0] res_q, res_d;
  logic [STAGES-1:0][WIDTH-1:0] x_q, x_d;
  logic [STAGES-1:0][WIDTH-1:0] y_q, y_d;
  logic                         ovf_q, ovf_d;
  logic                         zero_q, zero_d;
  logic                         unused_ops;

  // One segment: 4-bit groups with group P/G, bit carries by lookahead inside
  // each group, group carries chained by the lookahead unit.
  // Returns {carry into segment MSB, segment carry out, segment sum}.
  function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           c0);
    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG-1:0] s;
    logic [SEG:0]   c;
    logic           gp;
    logic           gg;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = c0;
    for (int j = 0; j < SEG / 4; j++) begin
      gp = &p[4*j +: 4];
      gg = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (&p[4*j+2 +: 2] & g[4*j+1])
         | (&p[4*j+1 +: 3] & g[4*j]);
      c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+4] = gg | (gp & c[4*j]);
    end
    s = p ^ c[SEG-1:0];
    return {c[SEG-1], c[SEG], s};
  endfunction

  assign advance   = !vld_q[LAST] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[LAST];
  assign sum       = res_q[LAST];
  assign cout      = cry_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign unused_ops = ^{x_q, y_q};

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH-1:0] x_s, y_s, r_s, r_new;
    logic             v_s, c_s;
    logic [SEG+1:0]   seg_r;

    if (k == 0) begin : g_first
      // Subtract stores ~b and forces the initial carry, ignoring cin.
      assign x_s = a;
      assign y_s = sub ? ~b : b;
      assign c_s = sub | cin;
      assign v_s = in_valid;
      assign r_s = '0;
    end else begin : g_next
      assign x_s = x_q[k-1];
      assign y_s = y_q[k-1];
      assign c_s = cry_q[k-1];
      assign v_s = vld_q[k-1];
      assign r_s = res_q[k-1];
    end

    assign seg_r = cla_seg(x_s[k*SEG +: SEG], y_s[k*SEG +: SEG], c_s);

    // Splice this segment's sum into the partial result from earlier segments
    always_comb begin
      r_new               = r_s;
      r_new[k*SEG +: SEG] = seg_r[SEG-1:0];
    end

    assign vld_d[k] = v_s;
    assign res_d[k] = r_new;
    assign x_d[k]   = x_s;
    assign y_d[k]   = y_s;
    assign cry_d[k] = seg_r[SEG];

    if (k == LAST) begin : g_flags
      assign ovf_d  = seg_r[SEG+1] ^ seg_r[SEG];
      assign zero_d = (r_new == '0);
    end else begin : g_mid
      logic unused_cmsb;
      assign unused_cmsb = seg_r[SEG+1];
    end
  end

  // Pipeline registers: all stages shift together on advance, hold otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      cry_q  <= '0;
      res_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      vld_q  <= vld_d;
      cry_q  <= cry_d;
      res_q  <= res_d;
      x_q    <= x_d;
      y_q    <= y_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_cla_pipelined_addsub.sv
// Bench for cla_pipelined_addsub: directed vectors on a STAGES=2 instance plus a
// shared random stream into STAGES=1,2,4,8 instances checked against a model.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_cla_pipelined_addsub;

  localparam int W    = 32;
  localparam int NDUT = 4;
  localparam int NOPS = 10000;
  localparam int NCYC = NOPS + 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            out_ready;
  logic            cin;
  logic            sub;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [NDUT-1:0] ir, ov, co, of, zr;
  logic [W-1:0]    sm [NDUT];

  int n_chk = 0;
  int n_err = 0;

  // {valid, cout, ovf, zero, sum} expected at the DUT inputs' cycle
  logic [35:0] hist [NCYC];

  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic        sc [8];
  logic        ss [8];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    cla_pipelined_addsub #(.WIDTH(W), .STAGES(1 << gi)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (ir[gi]),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(ov[gi]),
      .out_ready(out_ready),
      .sum      (sm[gi]),
      .cout     (co[gi]),
      .ovf      (of[gi]),
      .zero     (zr[gi])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input logic s);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = ci;
    sub      = s;
  endtask

  // Reference: plain 33-bit addition, signed overflow from operand/result signs
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic s);
    logic [31:0] yy;
    logic [32:0] r;
    logic        v;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {32'd0, (s ? 1'b1 : ci)};
    v  = (x[31] == yy[31]) && (r[31] != x[31]);
    return {1'b1, r[32], v, (r[31:0] == 32'd0), r[31:0]};
  endfunction

  function automatic logic [35:0] obs(input int i);
    return {ov[i], co[i], of[i], zr[i], sm[i]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    sa[0] = 32'h0000_0001; sb[0] = 32'h0000_0002; sc[0] = 1'b0; ss[0] = 1'b0;
    sa[1] = 32'h0000_0005; sb[1] = 32'h0000_0007; sc[1] = 1'b1; ss[1] = 1'b0;
    sa[2] = 32'h0000_000A; sb[2] = 32'h0000_0003; sc[2] = 1'b0; ss[2] = 1'b1;
    sa[3] = 32'h0000_0003; sb[3] = 32'h0000_000A; sc[3] = 1'b0; ss[3] = 1'b1;
    sa[4] = 32'h8000_0000; sb[4] = 32'h8000_0000; sc[4] = 1'b0; ss[4] = 1'b0;
    sa[5] = 32'h0000_FFFF; sb[5] = 32'h0000_0000; sc[5] = 1'b1; ss[5] = 1'b0;
    sa[6] = 32'h0000_0000; sb[6] = 32'h0000_0000; sc[6] = 1'b1; ss[6] = 1'b1;
    sa[7] = 32'h1234_5678; sb[7] = 32'h9ABC_DEF0; sc[7] = 1'b0; ss[7] = 1'b0;

    // Reset state
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_outs", obs(1), 36'h0);
    check("rst_valid_all", ov, 4'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", ir[1], 1'b1);

    // Wrap to zero, latency 2
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("t1_not_early", ov[1], 1'b0);
    @(negedge clk);
    check("t1_wrap", obs(1), 36'hD_0000_0000);

    // Subtract with signed overflow, then carry across the segment boundary
    drive(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("t2_sub_ovf", obs(1), 36'hA_8000_0000);
    @(negedge clk);
    check("t2_seg_carry", obs(1), 36'h8_0001_0000);

    // Eight back-to-back operations
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1'b1, sa[i], sb[i], sc[i], ss[i]);
      else       drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      if (i >= 1) check($sformatf("t3_stream%0d", i - 1), obs(1),
                        model(sa[i-1], sb[i-1], sc[i-1], ss[i-1]));
    end
    @(negedge clk);
    check("t3_drained", ov[1], 1'b0);

    // Stall with the pipe full
    out_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("t4_rdy_low%0d", s), ir[1], 1'b0);
      check($sformatf("t4_hold%0d", s), obs(1), 36'h8_3333_3333);
      if (s < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("t4_second", obs(1), 36'hD_0000_0000);
    @(negedge clk);
    check("t4_third", obs(1), 36'hC_FFFF_FFFF);
    @(negedge clk);
    check("t4_no_dup", ov[1], 1'b0);

    // Reset with two operations in flight
    drive(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("t5_inflight", obs(1), 36'h8_0000_0002);
    reset = 1'b1;
    #1;
    check("t5_rst_outs", obs(1), 36'h0);
    check("t5_rst_valid_all", ov, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check($sformatf("t5_no_stale%0d", s), ov, 4'h0);
      check($sformatf("t5_rdy%0d", s), ir[1], 1'b1);
    end

    // Random stream into all STAGES variants
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      int          st;
      logic [35:0] e;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic        rs;
      @(negedge clk);
      check("sweep_rdy", ir, 4'hF);
      for (int i = 0; i < NDUT; i++) begin
        st = 1 << i;
        e  = (c >= st) ? hist[c-st] : 36'h0;
        if (e[35]) check($sformatf("sweep_s%0d_c%0d", st, c), obs(i), e);
        else       check($sformatf("sweep_s%0d_idle_c%0d", st, c), ov[i], 1'b0);
      end
      if (c < NOPS && $urandom_range(0, 9) != 0) begin
        ra = pick();
        rb = pick();
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        drive(1'b1, ra, rb, rc, rs);
        hist[c] = model(ra, rb, rc, rs);
      end else begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        hist[c] = 36'h0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
